// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, 8 data bits LSB first, even/odd parity, stop bit.
// Every bit lasts CLKS_PER_BIT cycles. Legal values for CLKS_PER_BIT are 2..255.
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_odd,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);

  state_t     state;
  logic [7:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_q;
  logic       par_q;

  assign busy = ~in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      in_ready  <= 1'b1;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
      bit_cnt   <= 8'd0;
      bit_idx   <= 3'd0;
      data_q    <= 8'd0;
      par_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= START;
            tx       <= 1'b0;
            in_ready <= 1'b0;
            data_q   <= in_data;
            // Parity is fixed at accept so later input changes cannot leak in.
            par_q    <= (^in_data) ^ in_odd;
            bit_cnt  <= BIT_LAST;
            bit_idx  <= 3'd0;
          end
        end
        START: begin
          if (bit_cnt == 8'd0) begin
            state   <= DATA;
            tx      <= data_q[0];
            bit_cnt <= BIT_LAST;
            bit_idx <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        DATA: begin
          if (bit_cnt == 8'd0) begin
            bit_cnt <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
              tx    <= par_q;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= data_q[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        PARITY: begin
          if (bit_cnt == 8'd0) begin
            state   <= STOP;
            tx      <= 1'b1;
            bit_cnt <= BIT_LAST;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        STOP: begin
          if (bit_cnt == 8'd0) begin
            state     <= IDLE;
            tx        <= 1'b1;
            in_ready  <= 1'b1;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            bit_cnt <= bit_cnt - 8'd1;
          end
        end
        default: begin
          // Unused encodings fall back to a quiet idle line.
          state    <= IDLE;
          tx       <= 1'b1;
          in_ready <= 1'b1;
          bit_cnt  <= 8'd0;
          bit_idx  <= 3'd0;
        end
      endcase
    end
  end

endmodule
